// File: rtl/lib_switch_pkg.sv
// Shared helpers for the switch allocator: select-row to input-index conversion.
// Select rows are packed [0:N-1], so input 0 sits in the MSB of the row.
package lib_switch_pkg;

    localparam int MAX_PORTS = 32;

    // row holds a [0:n-1] select row right-aligned (input 0 at bit n-1).
    // Returns the lowest set input index, or n when the row is empty.
    function automatic int sel_to_idx(input logic [MAX_PORTS-1:0] row, input int n);
        int idx;
        idx = n;
        for (int b = 0; b < MAX_PORTS; b++) begin
            if (row[b] && b < n) begin
                idx = n - 1 - b;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lib_arbiter_rr_lock.sv
// Round-robin arbiter for one output with per-input grant locking; grant is registered
// (1 cycle from req to gnt). en=0 stalls the grant; ce=0 freezes all state.
module lib_arbiter_rr_lock
    import lib_switch_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce,
    input  logic [0:N-1] req,
    input  logic [0:N-1] lock,
    input  logic         en,
    output logic [0:N-1] gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] owner_d;
    logic          owner_vld_q;
    logic          owner_vld_d;
    logic [0:N-1]  gnt_q;
    logic [0:N-1]  gnt_d;
    logic [0:N-1]  pick;
    logic [IW-1:0] pick_idx;
    logic          lock_hit;

    // Two passes give the wrapped scan ptr..N-1 then 0..ptr-1.
    always_comb begin
        pick = '0;
        for (int k = 0; k < N; k++) begin
            if (pick == '0 && req[k] && IW'(k) >= ptr_q) begin
                pick[k] = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (pick == '0 && req[k]) begin
                pick[k] = 1'b1;
            end
        end
    end

    assign pick_idx = IW'(sel_to_idx(32'(pick), N));
    assign lock_hit = owner_vld_q && lock[owner_q] && req[owner_q];

    always_comb begin
        gnt_d       = '0;
        owner_d     = owner_q;
        owner_vld_d = 1'b0;
        ptr_d       = ptr_q;
        if (lock_hit) begin
            // Stalled lock keeps ownership but drives no select.
            owner_vld_d = 1'b1;
            if (en) begin
                gnt_d[owner_q] = 1'b1;
            end
        end else if (en && (req != '0)) begin
            gnt_d       = pick;
            owner_d     = pick_idx;
            owner_vld_d = 1'b1;
            ptr_d       = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gnt_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            ptr_q       <= '0;
        end else if (ce) begin
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt = gnt_q;

endmodule

// File: rtl/lib_switch_onehot_allocator.sv
// Switch allocator producing one-hot per-output input selects for the crossbar; 1 cycle
// req-to-select, no input-to-output combinational path. i_en stalls per output, ce freezes all.
module lib_switch_onehot_allocator
    import lib_switch_pkg::*;
#(
    parameter int N = 5,
    parameter int M = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic [0:N-1][0:M-1]  i_req,
    input  logic [0:N-1]         i_lock,
    input  logic [0:M-1]         i_en,
    output logic [0:M-1][0:N-1]  o_sel,
    output logic [0:N-1]         o_gnt
);

    logic [0:N-1][0:M-1] req_s;
    logic [0:N-1]        col [M];
    logic [0:N-1]        sel [M];

    // Keep only the lowest-index output per input so no input can win two outputs.
    always_comb begin
        req_s = '0;
        for (int n = 0; n < N; n++) begin
            for (int m = 0; m < M; m++) begin
                if (i_req[n][m] && req_s[n] == '0) begin
                    req_s[n][m] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < M; m++) begin
            col[m] = '0;
            for (int n = 0; n < N; n++) begin
                col[m][n] = req_s[n][m];
            end
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_arb
        lib_arbiter_rr_lock #(
            .N (N)
        ) u_arb (
            .clk     (clk),
            .reset_n (reset_n),
            .ce      (ce),
            .req     (col[m]),
            .lock    (i_lock),
            .en      (i_en[m]),
            .gnt     (sel[m])
        );
    end

    always_comb begin
        o_gnt = '0;
        for (int m = 0; m < M; m++) begin
            o_sel[m] = sel[m];
            o_gnt    = o_gnt | sel[m];
        end
    end

endmodule

// File: doc/lib_switch_onehot_allocator.md
Name: lib_switch_onehot_allocator

Overview:
- Switch allocator that generates the one-hot per-output input-select word consumed by the team's one-hot packet_t crossbar.
- Each output port runs an independent round-robin arbiter over the inputs requesting it.
- Supports per-input grant locking for multi-cycle transfers.
- Outputs are registered, so o_sel drives the crossbar select directly on the following cycle.

Parameters:
- N, 5, number of inputs (requesters); N >= 2
- M, 5, number of outputs (resources); M >= 1

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous, active-low reset
- ce  input  1  clock enable; when low, all state and outputs hold
- i_req  input  [0:N-1][0:M-1]  per-input request vector; bit [n][m] set means input n requests output m; at most one bit set per input
- i_lock  input  [0:N-1]  input n asks to keep its current grant next cycle
- i_en  input  [0:M-1]  output m may be granted this cycle (downstream ready)
- o_sel  output  [0:M-1][0:N-1]  one-hot or zero select per output; o_sel[m][n]=1 means output m takes input n. Index 0 is the MSB of each packed row, so o_sel[m] == 1<<(N-1-n) selects input n.
- o_gnt  output  [0:N-1]  input n currently holds some output; equals the OR over m of o_sel[m][n]

Behaviour:
- Reset (reset_n low at posedge clk, regardless of ce):
  - o_sel = 0, o_gnt = 0.
  - All round-robin pointers ptr[m] = 0.
  - All owner registers invalid.
- Latency: requests sampled at posedge with ce=1 appear in o_sel/o_gnt after that edge. This is 1 cycle; there is no combinational path from inputs to outputs.
- Request sanitising:
  - If i_req[n] has more than one bit set, only the lowest-index m is honoured; the other bits are ignored.
  - An all-zero row means no request.
- Per output m, each cycle with ce=1, evaluated in this order:
  - 1. Lock continuation: owner valid with owner = k, i_lock[k]=1, and sanitised req[k][m]=1.
    - If i_en[m]=1: o_sel[m] is held on k.
    - If i_en[m]=0: o_sel[m] = 0 and owner is retained.
    - ptr[m] is unchanged in both cases.
  - 2. Otherwise the owner is released. If i_en[m]=1 and any input requests m:
    - Grant the first requester found scanning ptr[m], ptr[m]+1, …, N-1, 0, …, ptr[m]-1.
    - o_sel[m] becomes one-hot at that input k.
    - owner[m] = k, valid.
    - ptr[m] = (k+1) mod N, wrapping from N-1 to 0.
  - 3. Otherwise (no request, or i_en[m]=0 with no lock): o_sel[m] = 0, owner invalid, ptr[m] unchanged.
- Because every input requests at most one output, no input is granted two outputs in the same cycle. o_gnt is therefore exact.
- Lock release: when i_lock[k] drops or k's request moves or clears, output m re-arbitrates that same cycle. k is not excluded, but it has the lowest priority because ptr = k+1.
- Fairness: with all N inputs continuously requesting m, no locks, and i_en[m]=1, grants rotate through every input exactly once every N cycles.
- ce=0: o_sel, o_gnt, ptr and owner all hold. Inputs are ignored.
- Reset asserted mid-lock: the lock is lost and outputs are 0 on the next cycle. The first grant after reset starts the scan from input 0.
- Invariants, checked by bench assertions:
  - each o_sel[m] is $onehot0
  - the o_sel columns are pairwise disjoint
  - o_gnt is consistent with o_sel

Decomposition:
- Shared package (lib_switch_pkg): a function that converts a one-hot select row to a binary input index, used by the bench and by the 'first requester found' logic. No packet_t dependency.
- Sub-module lib_arbiter_rr_lock, parameter N, instantiated M times:
  - Inputs: clk, reset_n, ce, req[0:N-1], lock, en.
  - Outputs: gnt[0:N-1], owner state and pointer internal.
  - The top level does request sanitising, transposes requests to per-output columns, and forms o_gnt.

Test Plan (N=5, M=5):
- 1. Reset: hold reset_n=0 with random i_req → o_sel=0 and o_gnt=0 for every cycle. On release with inputs 0 and 3 requesting output 2, the first grant is o_sel[2]=5'b10000 (input 0).
- 2. Round-robin: inputs 0–4 all request output 1, i_lock=0, i_en all 1, for 10 cycles → o_sel[1] cycles through inputs 0,1,2,3,4,0,1,2,3,4 and each o_gnt bit is high 2 of the 10 cycles.
- 3. Lock: input 2 granted output 4, then i_lock[2]=1 for 4 cycles while input 3 also requests 4 → o_sel[4] stays 5'b00100. When i_lock[2] drops, the next cycle grants input 3 (ptr=3).
- 4. Enable stall under lock: during test 3's lock, set i_en[4]=0 for 2 cycles → o_sel[4]=0 for those 2 cycles, then returns to input 2 without re-arbitration.
- 5. Parallel and illegal requests:
  - i_req[0]=5'b01100 (illegal, two bits set) → only output 1 is granted to input 0.
  - Simultaneously i_req[1] targets output 3 → o_sel[1]=5'b10000 and o_sel[3]=5'b01000 in the same cycle, with o_gnt=5'b11000.
- 6. ce hold: with a grant active, drop ce for 3 cycles while changing all inputs → o_sel, o_gnt and pointers are unchanged. Arbitration resumes from the held state on the first cycle ce=1.
